// File: rtl/axi4_mem_ctrl_if.sv
// AXI4 bus bundle between an AXI master and axi4_mem_ctrl (AW/W/B/AR/R channels).
interface axi4_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi4_mem_ctrl.sv
// AXI4 slave converting INCR bursts into single-port memory accesses, one burst at a time.
// Optional burst legality checking (SLVERR) is enabled by defining AXI4_MEM_CTRL_ERR_CHECK_EN.
module axi4_mem_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DEPTH          = 1024,
    parameter int ID_WIDTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    axi4_mem_ctrl_if.slave            axi,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_WAIT, RD_DATA} state_t;

    localparam logic [MEM_ADDR_WIDTH:0] DEPTH_W = (MEM_ADDR_WIDTH+1)'(DEPTH);

    state_t                    state, state_nxt;
    logic                      prio_wr;
    logic [ID_WIDTH-1:0]       id_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q, cnt_q;
    logic                      err_q;
    logic                      wr_done_q;
    logic                      wr_en_q;
    logic [MEM_ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]     wr_data_q, rdata_q;

    logic grant_wr, grant_rd, w_hs, last_cnt, w_end, w_err, aw_err, ar_err;

    assign grant_wr = axi.awvalid && (!axi.arvalid || prio_wr);
    assign grant_rd = axi.arvalid && (!axi.awvalid || !prio_wr);
    assign last_cnt = (cnt_q == len_q);
    assign w_hs     = (state == WR_DATA) && !wr_done_q && axi.wvalid;
    assign w_end    = axi.wlast || last_cnt;

`ifdef AXI4_MEM_CTRL_ERR_CHECK_EN
    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [MEM_ADDR_WIDTH:0] end_word;
        logic [12:0]             end_byte;
        end_word = {1'b0, addr[MEM_ADDR_WIDTH+1:2]} + (MEM_ADDR_WIDTH+1)'(len);
        // last byte touched by the burst; bit 12 set means it left the 4 KB page
        end_byte = {1'b0, addr[11:0]} + {3'b000, len, 2'b00} + 13'd3;
        return (burst != 2'b01) || (size != 3'd2) || (end_word >= DEPTH_W) || end_byte[12];
    endfunction

    assign aw_err = burst_err(axi.awaddr, axi.awlen, axi.awsize, axi.awburst);
    assign ar_err = burst_err(axi.araddr, axi.arlen, axi.arsize, axi.arburst);
    assign w_err  = err_q || (axi.wlast && !last_cnt);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
    assign w_err  = 1'b0;
`endif

    wire unused_ok = &{1'b0, axi.wstrb, axi.awaddr, axi.araddr, axi.awsize, axi.arsize,
                       axi.awburst, axi.arburst, DEPTH_W[0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The last write strobe drains in WR_DATA so the memory is idle while B is pending.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (grant_wr) state_nxt = WR_DATA;
                      else if (grant_rd) state_nxt = RD_ISSUE;
            WR_DATA:  if (wr_done_q) state_nxt = WR_RESP;
            WR_RESP:  if (axi.bready) state_nxt = IDLE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = RD_DATA;
            RD_DATA:  if (axi.rready) state_nxt = last_cnt ? IDLE : RD_ISSUE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        axi.awready = 1'b0;
        axi.arready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bid     = '0;
        axi.bresp   = 2'b00;
        axi.rvalid  = 1'b0;
        axi.rid     = '0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            IDLE: begin
                axi.awready = grant_wr;
                axi.arready = grant_rd;
            end
            WR_DATA: axi.wready = !wr_done_q;
            WR_RESP: begin
                axi.bvalid = 1'b1;
                axi.bid    = id_q;
                axi.bresp  = err_q ? 2'b10 : 2'b00;
            end
            RD_ISSUE: begin
                mem_en   = !err_q;
                mem_addr = addr_q;
            end
            RD_DATA: begin
                axi.rvalid = 1'b1;
                axi.rid    = id_q;
                axi.rdata  = rdata_q;
                axi.rresp  = err_q ? 2'b10 : 2'b00;
                axi.rlast  = last_cnt;
            end
            default: ;
        endcase
        if (wr_en_q) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr_q;
            mem_wdata = wr_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_wr   <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_done_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rdata_q   <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (state == IDLE && grant_wr) begin
                id_q      <= axi.awid;
                addr_q    <= axi.awaddr[MEM_ADDR_WIDTH+1:2];
                len_q     <= axi.awlen;
                cnt_q     <= '0;
                err_q     <= aw_err;
                wr_done_q <= 1'b0;
                prio_wr   <= 1'b0;
            end else if (state == IDLE && grant_rd) begin
                id_q    <= axi.arid;
                addr_q  <= axi.araddr[MEM_ADDR_WIDTH+1:2];
                len_q   <= axi.arlen;
                cnt_q   <= '0;
                err_q   <= ar_err;
                prio_wr <= 1'b1;
            end
            if (w_hs) begin
                wr_en_q   <= !w_err;
                wr_addr_q <= addr_q;
                wr_data_q <= axi.wdata;
                addr_q    <= addr_q + MEM_ADDR_WIDTH'(1);
                cnt_q     <= cnt_q + 8'd1;
                err_q     <= w_err;
                wr_done_q <= w_end;
            end
            if (state == RD_WAIT) rdata_q <= err_q ? '0 : mem_rdata;
            if (state == RD_DATA && axi.rready && !last_cnt) begin
                addr_q <= addr_q + MEM_ADDR_WIDTH'(1);
                cnt_q  <= cnt_q + 8'd1;
            end
        end
    end
endmodule
